// File: rtl/if_fetch_stage_if.sv
// Instruction-memory fetch bus: request/address out, single-cycle ready pulse with data back.
interface if_fetch_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );
endinterface

// File: rtl/if_fetch_stage.sv
// MIPS instruction-fetch stage: PC register, imem handshake, skid buffer for stalled returns,
// and the IF/ID pipeline register with flush and misaligned-fetch (AdEL) handling.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'hBFC0_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [31:0]              npc,
    output logic [31:0]              pc_o,
    input  logic                     stall,
    input  logic                     flush,
    if_fetch_stage_if.master         imem,
    output logic [31:0]              ifid_pc,
    output logic [31:0]              ifid_instr,
    output logic                     ifid_valid,
    output logic                     ifid_adel
);

    typedef enum logic [1:0] {
        StBoot,
        StFetch,
        StHold
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] skid_q, skid_d;
    logic [31:0] ifid_pc_q, ifid_pc_d;
    logic [31:0] ifid_instr_q, ifid_instr_d;
    logic        ifid_valid_q, ifid_valid_d;
    logic        ifid_adel_q, ifid_adel_d;

    logic        misaligned;

    assign misaligned     = (pc_q[1:0] != 2'b00);

    // Request depends only on registered state, so the address is stable while waiting.
    assign imem.imem_req  = (state_q == StFetch) && !misaligned;
    assign imem.imem_addr = pc_q;

    assign pc_o       = pc_q;
    assign ifid_pc    = ifid_pc_q;
    assign ifid_instr = ifid_instr_q;
    assign ifid_valid = ifid_valid_q;
    assign ifid_adel  = ifid_adel_q;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        skid_d       = skid_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_instr_d = ifid_instr_q;
        ifid_valid_d = ifid_valid_q;
        ifid_adel_d  = ifid_adel_q;

        unique case (state_q)
            StBoot: begin
                state_d = StFetch;
            end

            StFetch: begin
                if (flush) begin
                    ifid_pc_d    = 32'h0;
                    ifid_instr_d = NOP_INSTR;
                    ifid_valid_d = 1'b0;
                    ifid_adel_d  = 1'b0;
                    pc_d         = npc;
                end else if (misaligned) begin
                    // PC stays put until the exception unit redirects with a flush.
                    if (!stall) begin
                        ifid_pc_d    = pc_q;
                        ifid_instr_d = NOP_INSTR;
                        ifid_valid_d = 1'b1;
                        ifid_adel_d  = 1'b1;
                    end
                end else if (imem.imem_ready) begin
                    if (stall) begin
                        skid_d  = imem.imem_rdata;
                        state_d = StHold;
                    end else begin
                        ifid_pc_d    = pc_q;
                        ifid_instr_d = imem.imem_rdata;
                        ifid_valid_d = 1'b1;
                        ifid_adel_d  = 1'b0;
                        pc_d         = npc;
                    end
                end else if (!stall) begin
                    ifid_instr_d = NOP_INSTR;
                    ifid_valid_d = 1'b0;
                    ifid_adel_d  = 1'b0;
                end
            end

            StHold: begin
                if (flush) begin
                    ifid_pc_d    = 32'h0;
                    ifid_instr_d = NOP_INSTR;
                    ifid_valid_d = 1'b0;
                    ifid_adel_d  = 1'b0;
                    pc_d         = npc;
                    state_d      = StFetch;
                end else if (!stall) begin
                    ifid_pc_d    = pc_q;
                    ifid_instr_d = skid_q;
                    ifid_valid_d = 1'b1;
                    ifid_adel_d  = 1'b0;
                    pc_d         = npc;
                    state_d      = StFetch;
                end
            end

            default: begin
                state_d = StBoot;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StBoot;
            pc_q         <= RESET_PC;
            skid_q       <= 32'h0;
            ifid_pc_q    <= 32'h0;
            ifid_instr_q <= NOP_INSTR;
            ifid_valid_q <= 1'b0;
            ifid_adel_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            skid_q       <= skid_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_valid_q <= ifid_valid_d;
            ifid_adel_q  <= ifid_adel_d;
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Scoreboard bench for if_fetch_stage: a behavioural model predicts the post-edge outputs each
// cycle, a monitor pops and compares them one time unit after every rising edge.
module tb_if_fetch_stage;

    localparam logic [31:0] RESET_PC  = 32'hBFC0_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] npc;
    logic [31:0] pc_o;
    logic        stall;
    logic        flush;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_instr;
    logic        ifid_valid;
    logic        ifid_adel;

    if_fetch_stage_if bus ();

    if_fetch_stage #(
        .RESET_PC  (RESET_PC),
        .NOP_INSTR (NOP_INSTR)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .npc        (npc),
        .pc_o       (pc_o),
        .stall      (stall),
        .flush      (flush),
        .imem       (bus.master),
        .ifid_pc    (ifid_pc),
        .ifid_instr (ifid_instr),
        .ifid_valid (ifid_valid),
        .ifid_adel  (ifid_adel)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        req;
        logic [31:0] ipc;
        logic [31:0] instr;
        logic        valid;
        logic        adel;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   done    = 0;

    // Reference model: architectural view of the stage
    bit          m_boot;
    bit          m_waiting_release;  // a fetched word is parked while the pipe is stalled
    logic [31:0] m_pc, m_parked;
    logic [31:0] m_ipc, m_instr;
    bit          m_valid, m_adel;

    function automatic bit m_req();
        return !m_boot && !m_waiting_release && (m_pc % 4 == 0);
    endfunction

    function automatic void m_load(input logic [31:0] p, input logic [31:0] ins,
                                   input bit v, input bit a);
        m_ipc = p; m_instr = ins; m_valid = v; m_adel = a;
    endfunction

    function automatic void m_step(input bit rst, input logic [31:0] nx, input bit st,
                                   input bit fl, input bit rdy, input logic [31:0] rd);
        if (!rst) begin
            m_boot = 1; m_waiting_release = 0; m_pc = RESET_PC; m_parked = 0;
            m_load(0, NOP_INSTR, 0, 0);
        end else if (m_boot) begin
            m_boot = 0;
        end else if (fl) begin
            m_load(0, NOP_INSTR, 0, 0);
            m_pc = nx;
            m_waiting_release = 0;
        end else if (m_waiting_release) begin
            if (!st) begin
                m_load(m_pc, m_parked, 1, 0);
                m_pc = nx;
                m_waiting_release = 0;
            end
        end else if (m_pc % 4 != 0) begin
            if (!st) m_load(m_pc, NOP_INSTR, 1, 1);
        end else if (rdy) begin
            if (st) begin
                m_parked = rd;
                m_waiting_release = 1;
            end else begin
                m_load(m_pc, rd, 1, 0);
                m_pc = nx;
            end
        end else if (!st) begin
            m_instr = NOP_INSTR;
            m_valid = 0;
            m_adel  = 0;
        end
    endfunction

    task automatic cycle(input bit rst, input logic [31:0] nx, input bit st, input bit fl,
                         input bit rdy, input logic [31:0] rd);
        exp_t e;
        @(negedge clk);
        rst_n = rst; npc = nx; stall = st; flush = fl;
        bus.imem_ready = rdy; bus.imem_rdata = rd;
        m_step(rst, nx, st, fl, rdy, rd);
        e.pc = m_pc; e.req = m_req(); e.ipc = m_ipc; e.instr = m_instr;
        e.valid = m_valid; e.adel = m_adel;
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
        end
    endtask

    // Monitor: compares DUT outputs against the oldest prediction after each edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("pc_o", pc_o, e.pc);
                chk("imem_req", {31'b0, bus.imem_req}, {31'b0, e.req});
                chk("imem_addr", bus.imem_addr, e.pc);
                chk("ifid_pc", ifid_pc, e.ipc);
                chk("ifid_instr", ifid_instr, e.instr);
                chk("ifid_valid", {31'b0, ifid_valid}, {31'b0, e.valid});
                chk("ifid_adel", {31'b0, ifid_adel}, {31'b0, e.adel});
            end
        end
    end

    initial begin
        bit          rst, st, fl, rdy;
        logic [31:0] nx;
        int          r;

        rst_n = 1'b0; npc = '0; stall = 1'b0; flush = 1'b0;
        bus.imem_ready = 1'b0; bus.imem_rdata = '0;

        // Reset, then zero-wait streaming with ready tied high
        cycle(0, 32'h0, 0, 0, 0, 32'h0);
        cycle(0, 32'h0, 0, 0, 1, 32'h0);
        for (int i = 0; i < 6; i++) cycle(1, m_pc + 4, 0, 0, 1, $urandom);

        // Two wait states, then stall across a returned word for three cycles
        cycle(1, m_pc + 4, 0, 0, 0, 32'h0);
        cycle(1, m_pc + 4, 0, 0, 0, 32'h0);
        cycle(1, m_pc + 4, 0, 0, 1, 32'h1111_2222);
        cycle(1, m_pc + 4, 1, 0, 1, 32'h2408_0001);
        cycle(1, m_pc + 4, 1, 0, 0, 32'h0);
        cycle(1, m_pc + 4, 1, 0, 0, 32'h0);
        cycle(1, m_pc + 4, 0, 0, 0, 32'h0);

        // Flush while held and stalled
        cycle(1, m_pc + 4, 1, 0, 1, 32'h3333_4444);
        cycle(1, 32'hBFC0_0100, 1, 1, 0, 32'h0);
        cycle(1, m_pc + 4, 0, 0, 0, 32'h0);

        // Misaligned next PC, held until flushed to the exception vector
        cycle(1, 32'hBFC0_0102, 0, 0, 1, 32'h5555_6666);
        for (int i = 0; i < 3; i++) cycle(1, m_pc + 4, 0, 0, 0, 32'h0);
        cycle(1, 32'hBFC0_0380, 0, 1, 0, 32'h0);
        cycle(1, m_pc + 4, 0, 0, 1, 32'h7777_8888);

        // Reset with a request pending
        cycle(1, m_pc + 4, 0, 0, 0, 32'h0);
        cycle(0, m_pc + 4, 0, 0, 0, 32'h0);
        cycle(1, m_pc + 4, 0, 0, 1, 32'h9999_AAAA);

        // Randomised traffic
        for (int i = 0; i < 1500; i++) begin
            rst = ($urandom_range(0, 199) != 0);
            fl  = (m_pc % 4 != 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
            st  = ($urandom_range(0, 3) == 0);
            rdy = m_req() && ($urandom_range(0, 9) < 6);
            r   = $urandom_range(0, 19);
            if (r == 0)     nx = m_pc + 2;
            else if (r < 3) nx = $urandom & 32'hFFFF_FFFC;
            else            nx = m_pc + 4;
            cycle(rst, nx, st, fl, rdy, $urandom);
        end

        @(negedge clk);
        @(negedge clk);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
